// File: rtl/uart_tx_arb_if.sv
// Bundles the requester-side byte streams and the UART core handshake of uart_tx_arb.
interface uart_tx_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [2*NREQ-1:0] req_parity;
  logic [2*NREQ-1:0] req_stop;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [1:0]        cfg_parity;
  logic [1:0]        cfg_stop_bits;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              lock_abort;

  // Requesters plus UART core: drive byte streams and core ready, observe the arbiter
  modport master (
    output req_valid, req_data, req_last, req_parity, req_stop, tx_ready,
    input  req_ready, tx_data, tx_valid, cfg_parity, cfg_stop_bits, gnt, busy, lock_abort
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, req_parity, req_stop, tx_ready,
    output req_ready, tx_data, tx_valid, cfg_parity, cfg_stop_bits, gnt, busy, lock_abort
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART TX core among NREQ byte streams.
// Captures one byte per grant, hands it to the core and holds the winner's
// parity/stop configuration until the next capture.
// Optional packet lock: define UART_TX_ARB_LOCK_EN to keep the grant on one
// requester until its req_last byte, with a LOCK_TIMEOUT escape.
module uart_tx_arb #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  uart_tx_arb_if.slave  bus
);
  localparam int unsigned PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ARB, SEND, BUSY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;
  logic             grant;
  logic [NREQ-1:0]  eligible;

  // First eligible requester at or after the rotating pointer
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && eligible[(32'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PTR_W'((32'(ptr) + k) % NREQ);
      end
    end
    ptr_nxt = (32'(win) == NREQ - 1) ? '0 : PTR_W'(32'(win) + 1);
  end

  // Next-state logic; grant only when the core is idle and someone is eligible
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ARB: begin
        if (bus.tx_ready && found) begin
          grant     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND:    if (bus.tx_ready) state_nxt = BUSY;
      BUSY:    if (bus.tx_ready) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Single-cycle acknowledge to the winning requester
  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win] = 1'b1;
  end

  // State register with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      bus.tx_valid <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.tx_valid <= (state_nxt == SEND);
      bus.busy     <= (state_nxt != ARB);
    end
  end

  // Byte/config capture; cfg stays frozen until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tx_data       <= '0;
      bus.cfg_parity    <= '0;
      bus.cfg_stop_bits <= '0;
      bus.gnt           <= '0;
      ptr               <= '0;
    end else if (grant) begin
      bus.tx_data       <= bus.req_data[int'(win)*8 +: 8];
      bus.cfg_parity    <= bus.req_parity[int'(win)*2 +: 2];
      bus.cfg_stop_bits <= bus.req_stop[int'(win)*2 +: 2];
      bus.gnt           <= NREQ'(1) << win;
      ptr               <= ptr_nxt;
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic             locked;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] lock_cnt;
  logic [NREQ-1:0]  owner_mask;
  logic             stall;
  logic             expire;

  // Only the owner competes while its packet is open; idle owner runs the timeout
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    eligible          = locked ? (bus.req_valid & owner_mask) : bus.req_valid;
    stall             = (state == ARB) && locked && !bus.req_valid[owner];
    expire            = stall && (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));
  end

  // Lock ownership, idle counter and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      locked         <= 1'b0;
      owner          <= '0;
      lock_cnt       <= '0;
      bus.lock_abort <= 1'b0;
    end else begin
      bus.lock_abort <= 1'b0;
      if (grant) begin
        locked   <= !bus.req_last[win];
        owner    <= win;
        lock_cnt <= '0;
      end else if (expire) begin
        locked         <= 1'b0;
        lock_cnt       <= '0;
        bus.lock_abort <= 1'b1;
      end else if (stall) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_lock;

  // Every byte is arbitrated on its own; packet markers are ignored
  always_comb eligible = bus.req_valid;

  assign bus.lock_abort = 1'b0;
  assign unused_lock    = (^bus.req_last) ^ (LOCK_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed steps, scoreboard of expected frames
// checked at core acceptance, simple UART core model with a fixed frame length.
module tb_uart_tx_arb;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned FRAME = 6;

  typedef struct packed {
    logic [7:0]      data;
    logic [1:0]      par;
    logic [1:0]      stop;
    logic [NREQ-1:0] gnt;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   hold = 1'b0;
  bit   pkt_mode = 1'b0;
  int unsigned core_cnt = 0;

  int checks   = 0;
  int failures = 0;

  frame_t     exp_q[$];
  int         grant_log[$];
  int         last_grant;
  logic       obs_busy, obs_valid, obs_abort;
  logic [1:0] obs_stop;
  int unsigned rem      [NREQ];
  logic [7:0]  nxt_data [NREQ];
  logic [1:0]  cfg_par  [NREQ];
  logic [1:0]  cfg_stop [NREQ];
  bit          end_pkt  [NREQ];

  uart_tx_arb_if #(.NREQ(NREQ)) bus();

  uart_tx_arb #(.NREQ(NREQ), .LOCK_TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // UART core model: ready only while idle, busy FRAME cycles after each accept
  always_ff @(posedge clk) begin
    if (rst) core_cnt <= 0;
    else if (core_cnt != 0) core_cnt <= core_cnt - 1;
    else if (bus.tx_valid && bus.tx_ready) core_cnt <= FRAME;
  end
  assign bus.tx_ready = (core_cnt == 0) && !hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i);
    bus.req_valid[i]        = (rem[i] != 0);
    bus.req_data[8*i +: 8]  = nxt_data[i];
    bus.req_last[i]         = !pkt_mode || (rem[i] == 1 && end_pkt[i]);
    bus.req_parity[2*i +: 2] = cfg_par[i];
    bus.req_stop[2*i +: 2]   = cfg_stop[i];
  endtask

  task automatic load(input int i, input logic [7:0] d, input int unsigned n,
                      input logic [1:0] par, input logic [1:0] stop, input bit endp);
    rem[i] = n; nxt_data[i] = d; cfg_par[i] = par; cfg_stop[i] = stop; end_pkt[i] = endp;
    drive_req(i);
  endtask

  task automatic push_exp(input int i, input logic [7:0] d);
    frame_t e;
    e.data = d; e.par = cfg_par[i]; e.stop = cfg_stop[i]; e.gnt = NREQ'(1) << i;
    exp_q.push_back(e);
  endtask

  // One clock: observe at negedge, then update requesters just after posedge
  task automatic step();
    logic [NREQ-1:0] rdy;
    frame_t o, e;
    last_grant = -1;
    @(negedge clk);
    rdy = bus.req_ready;
    obs_busy = bus.busy; obs_valid = bus.tx_valid;
    obs_abort = bus.lock_abort; obs_stop = bus.cfg_stop_bits;
    if (rdy != '0) begin
      chk("ready_onehot", 32'($onehot(rdy)), 32'd1);
      chk("ready_valid", 32'(rdy & ~bus.req_valid), 32'd0);
      for (int i = 0; i < NREQ; i++) if (rdy[i]) last_grant = i;
      grant_log.push_back(last_grant);
    end
    if (bus.tx_valid && bus.tx_ready) begin
      o.data = bus.tx_data; o.par = bus.cfg_parity; o.stop = bus.cfg_stop_bits; o.gnt = bus.gnt;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty observed=0x%0h expected=none", o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_frame", 32'(o), 32'(e));
      end
    end
    @(posedge clk); #1;
    if (last_grant >= 0) begin
      rem[last_grant]--;
      nxt_data[last_grant]++;
      drive_req(last_grant);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((exp_q.size() != 0 || obs_busy) && n < budget);
    chk({tag, "_idle"}, 32'(exp_q.size() == 0 && !obs_busy), 32'd1);
  endtask

  function automatic int log_code();
    int c = 0;
    foreach (grant_log[k]) c = c * 16 + grant_log[k];
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) load(i, 8'h00, 0, 2'b00, 2'b00, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int arb;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    bus.req_parity = '0; bus.req_stop = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_cfg_parity", 32'(bus.cfg_parity), 32'd0);
    chk("rst_cfg_stop", 32'(bus.cfg_stop_bits), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_lock_abort", 32'(bus.lock_abort), 32'd0);
    @(posedge clk); #1;

    // Single request: req0 0xA5, parity 11, stop 0
    load(0, 8'hA5, 1, 2'b11, 2'b00, 1'b1);
    push_exp(0, 8'hA5);
    step();
    chk("t1_grant", 32'(last_grant), 32'd0);
    step();
    chk("t1_valid", 32'(obs_valid), 32'd1);
    chk("t1_busy", 32'(obs_busy), 32'd1);
    step();
    chk("t1_drop", 32'(obs_valid), 32'd0);
    chk("t1_busy_hold", 32'(obs_busy), 32'd1);
    wait_idle("t1", 30);

    // Fairness: all four valid, no grant while the core is held busy
    do_reset();
    hold = 1'b1;
    load(0, 8'h10, 2, 2'b01, 2'b00, 1'b1);
    load(1, 8'h21, 1, 2'b11, 2'b01, 1'b1);
    load(2, 8'h32, 1, 2'b00, 2'b10, 1'b1);
    load(3, 8'h43, 1, 2'b01, 2'b01, 1'b1);
    push_exp(0, 8'h10); push_exp(1, 8'h21); push_exp(2, 8'h32);
    push_exp(3, 8'h43); push_exp(0, 8'h11);
    grant_log.delete();
    repeat (4) step();
    chk("hold_no_grant", 32'(grant_log.size()), 32'd0);
    hold = 1'b0;
    wait_idle("fair", 100);
    chk("fair_len", 32'(grant_log.size()), 32'd5);
    chk("fair_order", 32'(log_code()), 32'h01230);

    // Config hold: req1 stop=2 in flight while req2 stop=1 waits
    load(1, 8'h3C, 1, 2'b01, 2'b10, 1'b1);
    push_exp(1, 8'h3C);
    step();
    chk("cfg_grant1", 32'(last_grant), 32'd1);
    load(2, 8'h5A, 1, 2'b00, 2'b01, 1'b1);
    push_exp(2, 8'h5A);
    for (int n = 0; n < 40; n++) begin
      step();
      chk("cfg_hold", 32'(obs_stop), 32'd2);
      if (last_grant == 2) break;
    end
    chk("cfg_grant2", 32'(last_grant), 32'd2);
    step();
    chk("cfg_new", 32'(obs_stop), 32'd1);
    wait_idle("cfg", 30);

    // Reset mid-frame: pointer returns to 0
    load(1, 8'h77, 1, 2'b00, 2'b00, 1'b1);
    push_exp(1, 8'h77);
    step();
    chk("mid_grant", 32'(last_grant), 32'd1);
    step();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    load(3, 8'h99, 1, 2'b10, 2'b01, 1'b1);
    load(1, 8'h66, 1, 2'b01, 2'b10, 1'b1);
    push_exp(1, 8'h66); push_exp(3, 8'h99);
    grant_log.delete();
    wait_idle("mid", 40);
    chk("mid_len", 32'(grant_log.size()), 32'd2);
    chk("mid_order", 32'(log_code()), 32'h13);

`ifdef UART_TX_ARB_LOCK_EN
    // Packet lock: req1 three-byte packet beats a waiting req0
    do_reset();
    pkt_mode = 1'b1;
    load(1, 8'hB0, 3, 2'b11, 2'b10, 1'b1);
    push_exp(1, 8'hB0); push_exp(1, 8'hB1); push_exp(1, 8'hB2);
    grant_log.delete();
    step();
    chk("lock_first", 32'(last_grant), 32'd1);
    load(0, 8'hC0, 1, 2'b01, 2'b00, 1'b1);
    push_exp(0, 8'hC0);
    wait_idle("lock", 80);
    chk("lock_len", 32'(grant_log.size()), 32'd4);
    chk("lock_order", 32'(log_code()), 32'h1110);

    // Lock timeout: req2 leaves its packet open, req0 waits
    load(2, 8'hD0, 1, 2'b00, 2'b01, 1'b0);
    push_exp(2, 8'hD0);
    step();
    chk("to_grant2", 32'(last_grant), 32'd2);
    load(0, 8'hE0, 1, 2'b10, 2'b10, 1'b1);
    push_exp(0, 8'hE0);
    arb = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (obs_abort) break;
      if (!obs_busy) arb++;
    end
    chk("to_abort_seen", 32'(obs_abort), 32'd1);
    chk("to_arb_cycles", 32'(arb), 32'd16);
    chk("to_grant0", 32'(last_grant), 32'd0);
    step();
    chk("to_abort_pulse", 32'(obs_abort), 32'd0);
    wait_idle("to", 30);
    pkt_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter core among NREQ byte-stream requesters.
- Captures one byte per grant, drives the core's data/valid handshake, and routes the winning requester's parity and stop-bit configuration to the core.
- The configuration is held stable for the whole frame.
- Optional packet lock keeps the grant on one requester until its last byte is sent.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, cycles the locked owner may leave req_valid low before the lock is dropped (only used with the lock feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NREQ  byte is last of packet (used only with lock feature)
- req_parity  in  2*NREQ  per-requester cfg_parity (bit0 enable, bit1 odd)
- req_stop  in  2*NREQ  per-requester stop bits (0=1, 1=1.5, 2=2)
- req_ready  out  NREQ  byte of requester i accepted this cycle
- tx_data  out  8  byte to core
- tx_valid  out  1  byte valid to core
- tx_ready  in  1  core ready (high only when core idle)
- cfg_parity  out  2  parity cfg to core
- cfg_stop_bits  out  2  stop cfg to core
- gnt  out  NREQ  one-hot current/last owner
- busy  out  1  frame in flight
- lock_abort  out  1  one-cycle pulse: lock dropped by timeout

Behaviour:
- Reset is synchronous, active-high: rst; clock clk.
- Reset values:
  - state ARB, tx_valid 0, tx_data 0, cfg_parity 0, cfg_stop_bits 0, gnt 0, busy 0, lock_abort 0.
  - Round-robin pointer 0 (requester 0 highest priority). Lock clear, timeout counter 0.
- Reset mid-frame aborts the current byte. Nothing is replayed. The core shares rst.
- States: ARB, SEND, BUSY.
- ARB:
  - Eligible set is req_valid, masked to the owner when locked.
  - If tx_ready=1 and eligible≠0: winner = first eligible at or after ptr, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally, this cycle only. At most one bit of req_ready is ever high.
  - Registered on that edge: tx_data, cfg_parity, cfg_stop_bits, gnt; ptr ← winner+1 mod NREQ; → SEND.
- SEND:
  - tx_valid=1, busy=1.
  - tx_ready=1 on a clock edge means the core accepted the byte: → BUSY, and tx_valid drops on that edge.
  - tx_data and cfg stay constant while tx_valid=1.
- BUSY:
  - busy=1, tx_valid=0.
  - Core ready falls the cycle after acceptance. → ARB when tx_ready=1 is seen.
  - cfg outputs stay unchanged until the next ARB capture.
- Latency:
  - req_ready to tx_valid is 1 cycle. With an idle core, core acceptance is on the same cycle tx_valid rises.
  - Back-to-back bytes: ARB takes 1 cycle after tx_ready returns.
- Simultaneous requests are resolved strictly by the rotating pointer. No starvation: each valid requester is served within NREQ grants.
- tx_ready=0 in ARB (core still busy after reset or external use) blocks all grants.
- cfg_* change only on ARB capture, never while the core is mid-frame.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined:
  - A capture with req_last[winner]=0 sets lock with owner=winner. Only the owner is eligible in ARB.
  - A capture with req_last=1 clears lock.
  - While locked in ARB with req_valid[owner]=0, a counter increments. At LOCK_TIMEOUT the lock clears, lock_abort pulses 1 cycle, and the counter returns to 0.
  - The counter clears on any owner capture.
  - ptr still advances to owner+1 on each capture.
- Undefined: req_last is ignored, no lock logic exists, lock_abort is tied 0, and every byte is arbitrated independently.

Test Plan:
- Single request: req0 sends 0xA5 with parity=2'b11, stop=0, core idle → req_ready[0] one cycle; next cycle tx_valid=1, tx_data=0xA5, cfg_parity=11; tx_valid drops after the core accepts; busy=1 until tx_ready returns.
- Fairness: req0..3 all hold valid continuously (NREQ=4) → grant order 0,1,2,3,0; one byte each; no grant while tx_ready=0.
- Config hold: req1 (stop=2) granted, then req2 (stop=1) valid during the frame → cfg_stop_bits stays 2 until req2's ARB capture, then becomes 1.
- Reset mid-frame: assert rst during BUSY → next cycle tx_valid=0, gnt=0, busy=0, ptr=0; a new req3 byte is then granted normally.
- Lock (UART_TX_ARB_LOCK_EN): req1 sends a 3-byte packet (last on byte 3) while req0 is valid → bytes 1,1,1 then 0; req0 never receives req_ready mid-packet.
- Lock timeout: LOCK_TIMEOUT=16; req2 sends 1 byte with last=0, then drops valid while req0 is valid → lock_abort pulses after 16 ARB cycles; req0 is granted on the next cycle.
